lcd_frame_arbiter: RTL

//  Shares the LCD pixel-data request of lcd_driver among P_NSRC pixel sources (colorbar, overlay, image buffer).

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_rr_picker.sv | 48 ++++
 rtl/lcd_frame_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame arbiter: FSM encodings, default
// panel timing and the RGB888 pixel width.
package lcd_pkg;

    // Frame-tracking FSM states
    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,   // position unknown, waiting for a vertical blank
        S_VBLANK = 2'd1,   // between frames, arbitration open
        S_ACTIVE = 2'd2    // frame in progress, ownership frozen
    } lcd_state_t;

    // Default panel timing (800x480 with 1056 clocks per line)
    localparam logic [10:0] H_TOTAL = 11'd1056;
    localparam logic [10:0] V_DISP  = 11'd480;

    // RGB888 pixel width
    localparam int RGB_W = 24;

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational arbiter: request vector (+ pointer) -> one-hot grant.
// Default build: round robin, search starts at pointer+1 mod P_NSRC and
// the winning index is returned so the caller can move its pointer.
// With LCD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the pointer/index ports disappear.
module lcd_rr_picker #(
    parameter int P_NSRC = 2
) (
    input  logic [P_NSRC-1:0]         i_req,
    output logic [P_NSRC-1:0]         o_grant
`ifndef LCD_ARB_FIXED_PRIO_EN
    ,
    input  logic [$clog2(P_NSRC)-1:0] i_ptr,
    output logic [$clog2(P_NSRC)-1:0] o_idx
`endif
);

`ifdef LCD_ARB_FIXED_PRIO_EN

    // Isolate the lowest set request bit (two's-complement trick)
    assign o_grant = i_req & (~i_req + {{(P_NSRC-1){1'b0}}, 1'b1});

`else

    localparam int IDX_W = $clog2(P_NSRC);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Rotating search starting just after the last owner
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= P_NSRC; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % P_NSRC);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

`endif

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Shares lcd_driver's pixel request among P_NSRC sources. Ownership only
// changes in vertical blanking, detected as a request gap of P_H_TOTAL
// clocks or as the end of the last active line, so every frame comes from
// one source. The grant commits on the first request of a frame and is
// routed immediately, so the owner sees that request.
// Build option: LCD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round robin.
module lcd_frame_arbiter
    import lcd_pkg::*;
#(
    parameter int               P_NSRC     = 2,
    parameter logic [10:0]      P_H_TOTAL  = H_TOTAL,
    parameter logic [10:0]      P_V_DISP   = V_DISP,
    parameter logic [RGB_W-1:0] P_BG_COLOR = 24'h000000
) (
    input  logic                      i_lcd_pclk,
    input  logic                      i_rst_n,
    input  logic                      i_data_req,
    input  logic [P_NSRC-1:0]         i_src_req,
    input  logic [P_NSRC*RGB_W-1:0]   i_src_data,
    output logic [P_NSRC-1:0]         o_src_grant,
    output logic [P_NSRC-1:0]         o_src_data_req,
    output logic [RGB_W-1:0]          o_pixel_data,
    output logic                      o_frame_start,
    output logic [10:0]               o_line_cnt
);

    lcd_state_t         r_state;
    lcd_state_t         w_state_nxt;
    logic [10:0]        r_gap;
    logic [10:0]        r_line_cnt;
    logic               r_req_d;
    logic               r_frame_start;
    logic               r_drop;
    logic [P_NSRC-1:0]  r_grant;
    logic [P_NSRC-1:0]  w_grant_nxt;
    logic [P_NSRC-1:0]  w_grant_eff;
    logic [RGB_W-1:0]   r_pixel;
    logic [RGB_W-1:0]   w_src_pix;
    logic               w_vblank_det;
    logic               w_req_rise;
    logic               w_req_fall;
    logic               w_commit;
    logic               w_line_inc;
    logic               w_pix_valid;

    assign w_vblank_det = (r_gap == P_H_TOTAL);
    assign w_req_rise   = i_data_req & ~r_req_d;
    assign w_req_fall   = ~i_data_req & r_req_d;

    // Idle-request gap counter, saturating at one full line time
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_gap <= '0;
        else if (i_data_req)
            r_gap <= '0;
        else if (r_gap != P_H_TOTAL)
            r_gap <= r_gap + 11'd1;
    end

    // Previous request level for edge detection
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_req_d <= 1'b0;
        else
            r_req_d <= i_data_req;
    end

`ifdef LCD_ARB_FIXED_PRIO_EN
    lcd_rr_picker #(
        .P_NSRC  (P_NSRC)
    ) u_picker (
        .i_req   (i_src_req),
        .o_grant (w_grant_nxt)
    );
`else
    logic [$clog2(P_NSRC)-1:0] r_ptr;
    logic [$clog2(P_NSRC)-1:0] w_pick_idx;

    lcd_rr_picker #(
        .P_NSRC  (P_NSRC)
    ) u_picker (
        .i_req   (i_src_req),
        .o_grant (w_grant_nxt),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx)
    );

    // Round-robin pointer follows the last nonzero grant
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ptr <= '0;
        else if (w_commit && (|w_grant_nxt))
            r_ptr <= w_pick_idx;
    end
`endif

    // FSM state register
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_SYNC;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state, grant commit and line-count strobes
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_line_inc  = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_vblank_det)
                    w_state_nxt = S_VBLANK;
            end
            S_VBLANK: begin
                if (w_req_rise) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_req_fall) begin
                    w_line_inc = 1'b1;
                    if ((r_line_cnt + 11'd1) == P_V_DISP)
                        w_state_nxt = S_VBLANK;
                end else if (w_vblank_det) begin
                    // Short frame: treat the long gap as blanking
                    w_state_nxt = S_VBLANK;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // Frame ownership, frame-start pulse, line count and owner-dropped flag
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant       <= '0;
            r_frame_start <= 1'b0;
            r_line_cnt    <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (w_commit) begin
                r_grant    <= w_grant_nxt;
                r_line_cnt <= '0;
                r_drop     <= 1'b0;
            end else begin
                if (w_line_inc)
                    r_line_cnt <= r_line_cnt + 11'd1;
                // Once the owner lets go, it stays blanked until the next commit
                if (|(r_grant & ~i_src_req))
                    r_drop <= 1'b1;
            end
        end
    end

    // On the commit cycle the new grant is not yet registered
    assign w_grant_eff = w_commit ? w_grant_nxt : r_grant;
    assign w_pix_valid = w_commit ? (|w_grant_nxt)
                                  : ((|(r_grant & i_src_req)) && !r_drop);

    // One-hot AND-OR mux of the owner's pixel bus
    always_comb begin
        w_src_pix = '0;
        for (int k = 0; k < P_NSRC; k++) begin
            if (w_grant_eff[k])
                w_src_pix = w_src_pix | i_src_data[k*RGB_W +: RGB_W];
        end
    end

    // Pixel register: data lands one clock after the request
    always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pixel <= P_BG_COLOR;
        else
            r_pixel <= w_pix_valid ? w_src_pix : P_BG_COLOR;
    end

    assign o_src_grant    = r_grant;
    assign o_src_data_req = {P_NSRC{i_data_req}} & w_grant_eff;
    assign o_pixel_data   = r_pixel;
    assign o_frame_start  = r_frame_start;
    assign o_line_cnt     = r_line_cnt;

endmodule
